// File: rtl/tcdm_cache_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_cache_req_queue
// Purpose  : Per-bank request buffer between one memory-side port of the
//            core-to-cache-bank crossbar and the request port of that bank.
//            In-order request FIFO decouples crossbar arbitration from bank
//            back-pressure; an outstanding-request counter caps the number
//            of requests in flight; responses pass straight through.
// Ports    : clk_i, rst_ni          clock (rising edge), async active-low reset
//            xbar_req_i  {q, q_valid}            request from crossbar
//            xbar_rsp_o  {p, p_valid, q_ready}   accept + response to crossbar
//            xbar_rsp_ready_i                    crossbar accepts response
//            bank_req_o  {q, q_valid}            request to cache bank
//            bank_rsp_i  {p, p_valid, q_ready}   bank ready + response
//            bank_rsp_ready_o                    response ready to bank
//            occupancy_o, outstanding_o, idle_o  status
// Option   : TCDM_CACHE_REQ_QUEUE_PERF_EN adds perf_req_cnt_o,
//            perf_stall_full_cnt_o, perf_stall_outst_cnt_o (32-bit, saturating)
// Revision : 1.0  initial release
// ============================================================================
module tcdm_cache_req_queue #(
    parameter int unsigned DEPTH           = 4,   // power of two, >= 2
    parameter int unsigned MAX_OUTSTANDING = 8,   // >= 1
    parameter int unsigned REQ_W           = 32,  // width of request payload q
    parameter int unsigned RSP_W           = 32,  // width of response payload p
    localparam int unsigned PTR_W          = $clog2(DEPTH) + 1,
    localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [REQ_W:0]     xbar_req_i,
    output logic [RSP_W+1:0]   xbar_rsp_o,
    input  logic               xbar_rsp_ready_i,
    output logic [REQ_W:0]     bank_req_o,
    input  logic [RSP_W+1:0]   bank_rsp_i,
    output logic               bank_rsp_ready_o,
    output logic [PTR_W-1:0]   occupancy_o,
    output logic [OUT_W-1:0]   outstanding_o,
    output logic               idle_o
`ifdef TCDM_CACHE_REQ_QUEUE_PERF_EN
    ,
    output logic [31:0]        perf_req_cnt_o,
    output logic [31:0]        perf_stall_full_cnt_o,
    output logic [31:0]        perf_stall_outst_cnt_o
`endif
);

    localparam logic [OUT_W-1:0] c_max_outst = OUT_W'(MAX_OUTSTANDING);

    // Field views of the packed channel ports
    logic             w_xbar_q_valid;
    logic [REQ_W-1:0] w_xbar_q;
    logic             w_bank_q_ready;
    logic             w_bank_p_valid;
    logic [RSP_W-1:0] w_bank_p;

    assign w_xbar_q_valid = xbar_req_i[0];
    assign w_xbar_q       = xbar_req_i[REQ_W:1];
    assign w_bank_q_ready = bank_rsp_i[0];
    assign w_bank_p_valid = bank_rsp_i[1];
    assign w_bank_p       = bank_rsp_i[RSP_W+1:2];

    // ------------------------------------------------------------------
    // Request FIFO: pointers carry an extra wrap bit so full and empty
    // are distinguishable without a separate count register.
    // ------------------------------------------------------------------
    logic [REQ_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OUT_W-1:0] r_outstanding;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_bank_q_valid;
    logic             w_rsp_hs;
    logic             w_inc;
    logic             w_dec;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]) &&
                     (r_wr_ptr[PTR_W-1]   != r_rd_ptr[PTR_W-1]);

    // Accept and issue depend only on registered state, so q_valid/q stay
    // stable until the bank handshakes (neither head nor count can move).
    assign w_push         = w_xbar_q_valid && !w_full;
    assign w_bank_q_valid = !w_empty && (r_outstanding != c_max_outst);
    assign w_pop          = w_bank_q_valid && w_bank_q_ready;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-2:0]] <= w_xbar_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outstanding counter. Illegal underflow/overflow events are dropped
    // so the count never wraps; the assertions below flag them.
    // ------------------------------------------------------------------
    assign w_rsp_hs = w_bank_p_valid && xbar_rsp_ready_i;
    assign w_dec    = w_rsp_hs && (r_outstanding != '0);
    assign w_inc    = w_pop && (r_outstanding != c_max_outst);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
        end else if (w_inc && !w_dec) begin
            r_outstanding <= r_outstanding + OUT_W'(1);
        end else if (w_dec && !w_inc) begin
            r_outstanding <= r_outstanding - OUT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bank_req_o       = {r_mem[r_rd_ptr[PTR_W-2:0]], w_bank_q_valid};
    assign xbar_rsp_o       = {w_bank_p, w_bank_p_valid, !w_full};
    assign bank_rsp_ready_o = xbar_rsp_ready_i;
    assign occupancy_o      = r_wr_ptr - r_rd_ptr;
    assign outstanding_o    = r_outstanding;
    assign idle_o           = w_empty && (r_outstanding == '0);

`ifdef TCDM_CACHE_REQ_QUEUE_PERF_EN
    logic [31:0] r_perf_req;
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_outst;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_req   <= '0;
            r_perf_full  <= '0;
            r_perf_outst <= '0;
        end else begin
            if (w_pop && (r_perf_req != '1))
                r_perf_req <= r_perf_req + 32'd1;
            if (w_xbar_q_valid && w_full && (r_perf_full != '1))
                r_perf_full <= r_perf_full + 32'd1;
            if (!w_empty && (r_outstanding == c_max_outst) && (r_perf_outst != '1))
                r_perf_outst <= r_perf_outst + 32'd1;
        end
    end

    assign perf_req_cnt_o         = r_perf_req;
    assign perf_stall_full_cnt_o  = r_perf_full;
    assign perf_stall_outst_cnt_o = r_perf_outst;
`endif

`ifndef SYNTHESIS
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_rsp_hs && (r_outstanding == '0)));
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_pop && (r_outstanding == c_max_outst)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_tcdm_cache_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcdm_cache_req_queue
// Purpose  : Self-checking bench for tcdm_cache_req_queue: vector table for
//            single-request flow, response pass-through and streaming, plus
//            sequences for FIFO full, in-flight cap and asynchronous reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_tcdm_cache_req_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        xv;
    logic [31:0] xq;
    logic        bqr;
    logic        bpv;
    logic [31:0] bp;
    logic        xr;

    logic [33:0] xbar_rsp;
    logic [32:0] bank_req;
    logic        bank_rsp_ready;
    logic [2:0]  occ;
    logic [3:0]  outst;
    logic        idle;
`ifdef TCDM_CACHE_REQ_QUEUE_PERF_EN
    logic [31:0] perf_req;
    logic [31:0] perf_full;
    logic [31:0] perf_outst;
`endif

    always #5 clk = ~clk;

    tcdm_cache_req_queue #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (8),
        .REQ_W           (32),
        .RSP_W           (32)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .xbar_req_i       ({xq, xv}),
        .xbar_rsp_o       (xbar_rsp),
        .xbar_rsp_ready_i (xr),
        .bank_req_o       (bank_req),
        .bank_rsp_i       ({bp, bpv, bqr}),
        .bank_rsp_ready_o (bank_rsp_ready),
        .occupancy_o      (occ),
        .outstanding_o    (outst),
        .idle_o           (idle)
`ifdef TCDM_CACHE_REQ_QUEUE_PERF_EN
        ,
        .perf_req_cnt_o         (perf_req),
        .perf_stall_full_cnt_o  (perf_full),
        .perf_stall_outst_cnt_o (perf_outst)
`endif
    );

    logic        xbar_q_ready;
    logic        xbar_p_valid;
    logic [31:0] xbar_p;
    logic        bank_v;
    logic [31:0] bank_q;
    assign xbar_q_ready = xbar_rsp[0];
    assign xbar_p_valid = xbar_rsp[1];
    assign xbar_p       = xbar_rsp[33:2];
    assign bank_v       = bank_req[0];
    assign bank_q       = bank_req[32:1];

    int checks = 0;
    int errors = 0;
    int issued_cnt = 0;

    // Bank-side handshake monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n && bank_v && bqr) issued_cnt = issued_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return to idle: answer every in-flight request, bank always ready
    task automatic drain(input string name);
        int n;
        n   = 0;
        xv  = 1'b0;
        xr  = 1'b1;
        bqr = 1'b1;
        while (idle !== 1'b1 && n < 40) begin
            bpv = (outst != 4'd0);
            bp  = 32'hD000 + n;
            tick();
            n++;
        end
        bpv = 1'b0;
        chk(name, idle, 1'b1);
    endtask

    typedef struct {
        logic        xv;
        logic [31:0] xq;
        logic        bqr;
        logic        pv;
        logic [31:0] p;
        logic        xr;
        logic        e_qready;
        logic        e_bank_v;
        logic [31:0] e_bank_q;
        logic [2:0]  e_occ;
        logic [3:0]  e_outst;
        logic        e_idle;
        logic        e_pv;
        logic [31:0] e_p;
        logic        e_brr;
    } vec_t;

    function automatic vec_t mk(
        input logic xv_, input logic [31:0] xq_, input logic bqr_, input logic pv_,
        input logic [31:0] p_, input logic xr_, input logic qr_, input logic bv_,
        input logic [31:0] bq_, input logic [2:0] occ_, input logic [3:0] out_,
        input logic idle_, input logic epv_, input logic [31:0] ep_, input logic brr_);
        vec_t v;
        v.xv = xv_; v.xq = xq_; v.bqr = bqr_; v.pv = pv_; v.p = p_; v.xr = xr_;
        v.e_qready = qr_; v.e_bank_v = bv_; v.e_bank_q = bq_; v.e_occ = occ_;
        v.e_outst = out_; v.e_idle = idle_; v.e_pv = epv_; v.e_p = ep_; v.e_brr = brr_;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, got, pushed, base, exp_perf;
        logic acc;

        //          xv  xq       bqr pv  p         xr | qr bv bank_q   occ out idle pv p        brr
        vecs[0]  = mk(1, 32'h40,  1, 0, 32'h0,    1,   1, 0, 32'h0,   0,  0,  1,  0, 32'h0,    1);
        vecs[1]  = mk(0, 32'h0,   1, 0, 32'h0,    1,   1, 1, 32'h40,  1,  0,  0,  0, 32'h0,    1);
        vecs[2]  = mk(0, 32'h0,   1, 0, 32'h0,    1,   1, 0, 32'h0,   0,  1,  0,  0, 32'h0,    1);
        vecs[3]  = mk(0, 32'h0,   1, 1, 32'h1111, 0,   1, 0, 32'h0,   0,  1,  0,  1, 32'h1111, 0);
        vecs[4]  = mk(0, 32'h0,   1, 1, 32'hABCD, 1,   1, 0, 32'h0,   0,  1,  0,  1, 32'hABCD, 1);
        vecs[5]  = mk(0, 32'h0,   1, 0, 32'h0,    1,   1, 0, 32'h0,   0,  0,  1,  0, 32'h0,    1);
        vecs[6]  = mk(1, 32'h101, 1, 0, 32'h0,    1,   1, 0, 32'h0,   0,  0,  1,  0, 32'h0,    1);
        vecs[7]  = mk(1, 32'h102, 1, 0, 32'h0,    1,   1, 1, 32'h101, 1,  0,  0,  0, 32'h0,    1);
        vecs[8]  = mk(1, 32'h103, 1, 0, 32'h0,    1,   1, 1, 32'h102, 1,  1,  0,  0, 32'h0,    1);
        vecs[9]  = mk(1, 32'h104, 1, 0, 32'h0,    1,   1, 1, 32'h103, 1,  2,  0,  0, 32'h0,    1);
        vecs[10] = mk(0, 32'h0,   1, 1, 32'h5,    1,   1, 1, 32'h104, 1,  3,  0,  1, 32'h5,    1);
        vecs[11] = mk(0, 32'h0,   1, 1, 32'h6,    1,   1, 0, 32'h0,   0,  3,  0,  1, 32'h6,    1);
        vecs[12] = mk(0, 32'h0,   1, 1, 32'h7,    1,   1, 0, 32'h0,   0,  2,  0,  1, 32'h7,    1);
        vecs[13] = mk(0, 32'h0,   1, 1, 32'h8,    1,   1, 0, 32'h0,   0,  1,  0,  1, 32'h8,    1);
        vecs[14] = mk(0, 32'h0,   1, 0, 32'h0,    1,   1, 0, 32'h0,   0,  0,  1,  0, 32'h0,    1);

        // Reset state; response path must follow inputs even in reset
        rst_n = 1'b0; xv = 1'b0; xq = '0; bqr = 1'b0; bpv = 1'b1; bp = 32'h77; xr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_q_ready", xbar_q_ready, 1'b1);
        chk("rst_bank_v", bank_v, 1'b0);
        chk("rst_occ", occ, 3'd0);
        chk("rst_outst", outst, 4'd0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_p_valid", xbar_p_valid, 1'b1);
        chk("rst_p", xbar_p, 32'h77);
        @(posedge clk);
        #1;
        bpv = 1'b0; bp = '0; rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 15; i++) begin
            xv = vecs[i].xv; xq = vecs[i].xq; bqr = vecs[i].bqr;
            bpv = vecs[i].pv; bp = vecs[i].p; xr = vecs[i].xr;
            @(negedge clk);
            chk($sformatf("v%0d_q_ready", i), xbar_q_ready, vecs[i].e_qready);
            chk($sformatf("v%0d_bank_v", i), bank_v, vecs[i].e_bank_v);
            if (vecs[i].e_bank_v) chk($sformatf("v%0d_bank_q", i), bank_q, vecs[i].e_bank_q);
            chk($sformatf("v%0d_occ", i), occ, vecs[i].e_occ);
            chk($sformatf("v%0d_outst", i), outst, vecs[i].e_outst);
            chk($sformatf("v%0d_idle", i), idle, vecs[i].e_idle);
            chk($sformatf("v%0d_p_valid", i), xbar_p_valid, vecs[i].e_pv);
            if (vecs[i].e_pv) chk($sformatf("v%0d_p", i), xbar_p, vecs[i].e_p);
            chk($sformatf("v%0d_bank_rsp_ready", i), bank_rsp_ready, vecs[i].e_brr);
            tick();
        end

        // FIFO full: bank stalled, 5 back-to-back requests
        bqr = 1'b0; bpv = 1'b0; xr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            xv = 1'b1; xq = 32'h200 + i;
            @(negedge clk);
            if (i < 4) begin
                chk($sformatf("full_q_ready_%0d", i), xbar_q_ready, 1'b1);
                tick();
            end else begin
                chk("full_q_ready_5th", xbar_q_ready, 1'b0);
                chk("full_occ", occ, 3'd4);
                chk("full_head_valid", bank_v, 1'b1);
                chk("full_head_q", bank_q, 32'h200);
            end
        end
        tick();
        bqr = 1'b1;
        got = 0; n = 0;
        while (got < 5 && n < 30) begin
            @(negedge clk);
            acc = xv && xbar_q_ready;
            if (bank_v) begin
                chk($sformatf("full_order_%0d", got), bank_q, 32'h200 + got);
                got++;
            end
            tick();
            if (acc) xv = 1'b0;
            n++;
        end
        chk("full_all_issued", got, 5);
        drain("full_drain_idle");

        // In-flight cap: bank ready, responses withheld, 10 requests
        base = issued_cnt; pushed = 0; n = 0; bqr = 1'b1; bpv = 1'b0;
        while (pushed < 10 && n < 60) begin
            xv = 1'b1; xq = 32'h300 + pushed;
            @(negedge clk);
            acc = xbar_q_ready;
            tick();
            if (acc) pushed++;
            n++;
        end
        xv = 1'b0;
        chk("cap_pushed", pushed, 10);
        repeat (3) tick();
        @(negedge clk);
        chk("cap_issued", issued_cnt - base, 8);
        chk("cap_outst", outst, 4'd8);
        chk("cap_bank_v", bank_v, 1'b0);
        chk("cap_occ", occ, 3'd2);
        tick();
        bpv = 1'b1; bp = 32'h99;
        @(negedge clk);
        chk("cap_rsp_same_cycle_blocked", bank_v, 1'b0);
        chk("cap_rsp_pass", xbar_p, 32'h99);
        tick();
        bpv = 1'b0;
        @(negedge clk);
        chk("cap_release_v", bank_v, 1'b1);
        chk("cap_release_q", bank_q, 32'h308);
        chk("cap_release_outst", outst, 4'd7);
        tick();
        @(negedge clk);
        chk("cap_reblocked_v", bank_v, 1'b0);
        chk("cap_reblocked_outst", outst, 4'd8);
        chk("cap_reblocked_occ", occ, 3'd1);
        chk("cap_issued_9", issued_cnt - base, 9);
        tick();
        drain("cap_drain_idle");

        // Mid-operation asynchronous reset with 3 queued, 2 outstanding
        bqr = 1'b1; xv = 1'b1; xq = 32'h400; tick();
        xq = 32'h401; tick();
        xq = 32'h402; tick();
        bqr = 1'b0; xq = 32'h403; tick();
        xq = 32'h404; tick();
        xv = 1'b0;
        @(negedge clk);
        chk("pre_rst_occ", occ, 3'd3);
        chk("pre_rst_outst", outst, 4'd2);
        exp_perf = issued_cnt;
`ifdef TCDM_CACHE_REQ_QUEUE_PERF_EN
        chk("pre_rst_perf_req", perf_req, exp_perf);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_occ", occ, 3'd0);
        chk("arst_outst", outst, 4'd0);
        chk("arst_q_ready", xbar_q_ready, 1'b1);
        chk("arst_bank_v", bank_v, 1'b0);
        chk("arst_idle", idle, 1'b1);
`ifdef TCDM_CACHE_REQ_QUEUE_PERF_EN
        chk("arst_perf_req", perf_req, 32'd0);
        chk("arst_perf_full", perf_full, 32'd0);
        chk("arst_perf_outst", perf_outst, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
